// File: rtl/reg_dump_unit.sv
// reg_dump_unit
// Sequential read-out engine for the register file. A start pulse accepted in
// IDLE latches an inclusive address range [first_addr, last_addr] (wrapping
// modulo 2**D). The unit then walks that range. For each entry it drives
// rd_addr, snapshots rd_data into an output register and offers it on a
// valid/ready stream. It keeps a running XOR checksum of every accepted word.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   start               dump request, sampled only in IDLE
//   first_addr          first register of the range (latched on start)
//   last_addr           last register of the range, inclusive (latched on start)
//   rd_addr / rd_data   combinational read port of the register file
//   out_valid/out_ready entry stream handshake
//   out_data/out_addr   captured entry and its address
//   busy                high in CAPTURE, SEND and DONE
//   done                one-cycle pulse at the end of a dump
//   checksum            XOR of all accepted out_data words of the current/last dump
//   dbg_state           current FSM state, for observation only
//
// Handshake: an entry is transferred on every rising CLK edge where out_valid
// and out_ready are both high. While out_valid is high and no transfer has
// happened, out_data and out_addr stay stable. out_valid never drops
// without a transfer, except on reset.
module reg_dump_unit #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [D-1:0] first_addr,
  input  logic [D-1:0] last_addr,
  output logic [D-1:0] rd_addr,
  input  logic [W-1:0] rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [D-1:0] out_addr,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] checksum,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SEND    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [D-1:0] cur_addr_q, cur_addr_d;
  logic [D-1:0] end_addr_q, end_addr_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [D-1:0] out_addr_q, out_addr_d;
  logic [W-1:0] checksum_q, checksum_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      end_addr_q <= end_addr_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    end_addr_d = end_addr_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d = first_addr;
          end_addr_d = last_addr;
          checksum_d = '0;
          state_d    = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // Snapshot, so later register-file writes cannot alter the offered word.
        out_data_d = rd_data;
        out_addr_d = cur_addr_q;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          checksum_d = checksum_q ^ out_data_q;
          // The end is detected by equality, so first==last is a single entry.
          // The +1 wraps naturally at 2**D.
          if (cur_addr_q == end_addr_q) begin
            state_d = S_DONE;
          end else begin
            cur_addr_d = cur_addr_q + D'(1);
            state_d    = S_CAPTURE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // rd_addr follows cur_addr in every state, so the shared read mux sees no glitch.
  assign rd_addr   = cur_addr_q;
  assign out_valid = (state_q == S_SEND);
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign checksum  = checksum_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
module tb_reg_dump_unit;
  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 1 << D;

  // ---------------- clock / reset / DUT ----------------
  logic         CLK = 1'b0;
  logic         RST_N;
  logic         start;
  logic [D-1:0] first_addr, last_addr;
  logic [D-1:0] rd_addr;
  logic [W-1:0] rd_data;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic [D-1:0] out_addr;
  logic         busy, done;
  logic [W-1:0] checksum;
  logic [1:0]   dbg_state;

  always #5 CLK = ~CLK;

  reg_dump_unit #(.W(W), .D(D)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done), .checksum(checksum), .dbg_state(dbg_state)
  );

  // Register file model with a combinational read port.
  logic [W-1:0] regs [N];
  assign rd_data = regs[rd_addr];

  // ---------------- scoreboard ----------------
  logic [D+W-1:0] exp_q[$];      // {addr, data} expected per accepted word
  logic [W-1:0]   exp_ck_q[$];   // expected checksum per dump
  logic [W-1:0]   last_ck = '0;
  int errors = 0;
  int checks = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: a word is accepted on the edge following a negedge where valid&ready.
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          logic [D+W-1:0] e;
          e = exp_q.pop_front();
          check("word_addr", 32'(out_addr), 32'(e[D+W-1:W]));
          check("word_data", 32'(out_data), 32'(e[W-1:0]));
        end
      end
      if (done) begin
        check("words_left_at_done", exp_q.size(), 0);
        if (exp_ck_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [W-1:0] c;
          c = exp_ck_q.pop_front();
          check("checksum_at_done", 32'(checksum), 32'(c));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called one step after a rising edge while the DUT is idle. The reference
  // model lists the visited range with modular arithmetic.
  task automatic issue_start(input int f, input int l);
    int n;
    logic [W-1:0] ck;
    logic [D-1:0] a;
    n  = (((l - f) % N) + N) % N + 1;
    ck = '0;
    for (int i = 0; i < n; i++) begin
      a = D'((f + i) % N);
      exp_q.push_back({a, regs[a]});
      ck = ck ^ regs[a];
    end
    exp_ck_q.push_back(ck);
    last_ck    = ck;
    first_addr = D'(f);
    last_addr  = D'(l);
    start      = 1'b1;
    @(posedge CLK);
    #1;
    start      = 1'b0;
    first_addr = D'($urandom);
    last_addr  = D'($urandom);
  endtask

  // Waits for done. The cycle count is 1 for the cycle after the start edge.
  task automatic wait_done(input int budget, input bit rand_ready, input int exp_cyc);
    int cyc;
    cyc = 0;
    for (int k = 1; k <= budget; k++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLK);
      check("busy_during_dump", 32'(busy), 1);
      if (done) begin
        cyc = k;
        break;
      end
      @(posedge CLK);
      #1;
    end
    if (cyc == 0) check("done_timeout", 0, 1);
    else if (exp_cyc >= 0) check("done_cycle", cyc, exp_cyc);
    @(posedge CLK);
    #1;
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("checksum_hold", 32'(checksum), 32'(last_ck));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RST_N = 1'b0; start = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i < N; i++) regs[i] = W'(8'h10 + i);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_checksum", 32'(checksum), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_addr", 32'(out_addr), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Full range, no backpressure.
    issue_start(0, 7);
    wait_done(100, 1'b0, 17);

    // Wrapping range.
    issue_start(6, 1);
    wait_done(100, 1'b0, 9);

    // Single entry.
    issue_start(3, 3);
    wait_done(20, 1'b0, 3);

    // Backpressure with a register write during the stall.
    out_ready = 1'b0;
    issue_start(0, 7);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      #1;
      if (k == 1) regs[0] = 8'hAA;
      @(negedge CLK);
      check("stall_valid", 32'(out_valid), 1);
      check("stall_data", 32'(out_data), 32'h10);
      check("stall_addr", 32'(out_addr), 0);
    end
    wait_done(100, 1'b0, -1);
    regs[0] = 8'h10;

    // start during a dump is ignored.
    out_ready = 1'b1;
    issue_start(0, 7);
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    first_addr = 3'd5; last_addr = 3'd5; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_done(100, 1'b0, -1);

    // Reset while the third word is offered.
    out_ready = 1'b1;
    issue_start(0, 7);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge CLK);
        if (out_valid && out_addr == 3'd2) begin
          seen = 1'b1;
          break;
        end
      end
      check("third_word_seen", 32'(seen), 1);
    end
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_checksum", 32'(checksum), 0);
    check("arst_out_data", 32'(out_data), 0);
    check("arst_done", 32'(done), 0);
    exp_q.delete();
    exp_ck_q.delete();
    last_ck = '0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("post_rst_done", 32'(done), 0);
      check("post_rst_busy", 32'(busy), 0);
    end
    @(posedge CLK);
    #1;
    issue_start(0, 1);
    wait_done(20, 1'b0, 5);

    // Randomized dumps with random register contents and random backpressure.
    repeat (12) begin
      for (int i = 0; i < N; i++) regs[i] = W'($urandom);
      issue_start($urandom_range(0, N - 1), $urandom_range(0, N - 1));
      wait_done(400, 1'b1, -1);
    end

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog keeps the run bounded whatever the DUT does.
  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
